laser_pulse_timer: RTL and testbench

Multi-channel, parametrised laser pulse timer. Each channel holds its output high for a programmable number of cycles after a trigger, then enforces a fixed cooldown before it accepts a new trigger. Retrigger (extend) mode and a global kill are selectable at run time. The block sits between debounced trigger inputs and the laser-enable drivers, and succeeds the fixed 3-cycle single-channel timer.

---
 rtl/laser_timer_pkg.sv | 6 +
 rtl/laser_timer_ch.sv | 60 ++++++
 rtl/laser_pulse_timer.sv | 34 +++
 tb/tb_laser_pulse_timer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/laser_timer_pkg.sv
// laser_timer_pkg: shared state encoding and constants for the laser pulse timer.
package laser_timer_pkg;
   typedef enum logic [1:0] {OFF, ON, COOL} state_t;
   // A zero duration is clamped to this many ON cycles.
   localparam int MIN_DUR = 1;
endpackage

// File: rtl/laser_timer_ch.sv
// laser_timer_ch: one pulse channel with ON/COOL/OFF sequencing, down-counter and done strobe.
module laser_timer_ch
   import laser_timer_pkg::*;
#(
   parameter int W        = 8,
   parameter int COOL_CYC = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         b,
   input  logic [W-1:0] dur,
   input  logic         retrig,
   input  logic         kill,
   output logic         x,
   output logic         done,
   output logic         active
);
   localparam logic [W-1:0] ONE = W'(1);
   state_t       state;
   logic [W-1:0] cnt;
   logic [W-1:0] load;
   assign load   = (dur == '0) ? W'(MIN_DUR) : dur;
   assign x      = state == ON;
   assign active = state != OFF;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OFF;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            state <= OFF;
            cnt   <= '0;
         end else begin
            case (state)
               OFF: if (b) begin
                  state <= ON;
                  cnt   <= load;
               end
               // Reload outranks expiry when both happen on the same edge.
               ON: if (retrig && b) cnt <= load;
                  else if (cnt == ONE) begin
                     done  <= 1'b1;
                     state <= (COOL_CYC == 0) ? OFF : COOL;
                     cnt   <= W'(COOL_CYC);
                  end else cnt <= cnt - ONE;
               COOL: if (cnt == ONE) begin
                  state <= OFF;
                  cnt   <= '0;
               end else cnt <= cnt - ONE;
               default: begin
                  state <= OFF;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/laser_pulse_timer.sv
// laser_pulse_timer: CH independent laser pulse channels with shared duration, retrigger and kill.
module laser_pulse_timer
   import laser_timer_pkg::*;
#(
   parameter int CH       = 4,
   parameter int W        = 8,
   parameter int COOL_CYC = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] b,
   input  logic [W-1:0]  dur,
   input  logic          retrig,
   input  logic          kill,
   output logic [CH-1:0] x,
   output logic [CH-1:0] done,
   output logic          busy
);
   logic [CH-1:0] active;
   for (genvar i = 0; i < CH; i++) begin : g_ch
      laser_timer_ch #(.W(W), .COOL_CYC(COOL_CYC)) u_ch (
         .clk(clk),
         .rst(rst),
         .b(b[i]),
         .dur(dur),
         .retrig(retrig),
         .kill(kill),
         .x(x[i]),
         .done(done[i]),
         .active(active[i])
      );
   end
   assign busy = |active;
endmodule

// File: tb/tb_laser_pulse_timer.sv
// tb_laser_pulse_timer: directed and random stimulus checked against a timestamp-based model.
module tb_laser_pulse_timer;
   localparam int CH = 4;
   localparam int W = 8;
   localparam int C = 2;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] b = '0;
   logic [W-1:0]  dur = '0;
   logic          retrig = 1'b0;
   logic          kill = 1'b0;
   logic [CH-1:0] x;
   logic [CH-1:0] done;
   logic          busy;
   int            checks = 0;
   int            errors = 0;
   // Model: absolute edge numbers at which the pulse ends and the cooldown ends.
   longint        t = 0;
   longint        on_until [CH];
   longint        cool_until [CH];
   logic [CH-1:0] ex, ed;
   logic          eb;
   int            hi [CH];
   int            dn [CH];
   int            bc;

   laser_pulse_timer #(.CH(CH), .W(W), .COOL_CYC(C)) dut (
      .clk(clk), .rst(rst), .b(b), .dur(dur), .retrig(retrig), .kill(kill),
      .x(x), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         on_until[i] = 0;
         cool_until[i] = 0;
      end
   endtask

   task automatic clr();
      for (int i = 0; i < CH; i++) begin
         hi[i] = 0;
         dn[i] = 0;
      end
      bc = 0;
   endtask

   task automatic model_edge();
      longint d;
      logic was_on, was_cool;
      d = (dur == 0) ? 1 : longint'(dur);
      eb = 1'b0;
      for (int i = 0; i < CH; i++) begin
         was_on = on_until[i] >= t;
         was_cool = !was_on && cool_until[i] >= t;
         ed[i] = 1'b0;
         if (kill) begin
            on_until[i] = t;
            cool_until[i] = t;
         end else if (b[i] && ((!was_on && !was_cool) || (was_on && retrig))) begin
            on_until[i] = t + d;
            cool_until[i] = t + d + C;
         end else if (was_on && on_until[i] == t) ed[i] = 1'b1;
         ex[i] = on_until[i] > t;
         eb |= cool_until[i] > t;
      end
   endtask

   task automatic step(input logic [CH-1:0] bb, input logic [W-1:0] dd, input logic rr, input logic kk);
      @(negedge clk);
      b = bb;
      dur = dd;
      retrig = rr;
      kill = kk;
      @(posedge clk);
      t++;
      model_edge();
      #1;
      chk("x", x, ex);
      chk("done", done, ed);
      chk("busy", busy, eb);
      for (int i = 0; i < CH; i++) begin
         hi[i] += x[i];
         dn[i] += done[i];
      end
      bc += busy;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, dur, retrig, 1'b0);
   endtask

   initial begin
      model_reset();
      #12;
      chk("reset_x", x, 0);
      chk("reset_done", done, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      // Single trigger, dur=3
      clr();
      step(4'b0001, 8'd3, 1'b0, 1'b0);
      idle(7);
      chk("single_hi", hi[0], 3);
      chk("single_done", dn[0], 1);
      chk("single_busy", bc, 5);
      chk("single_others", hi[1] + hi[2] + hi[3], 0);
      // Zero and max duration
      clr();
      step(4'b0010, 8'd0, 1'b0, 1'b0);
      idle(4);
      chk("dur0_hi", hi[1], 1);
      clr();
      step(4'b0001, 8'd255, 1'b0, 1'b0);
      idle(260);
      chk("dur255_hi", hi[0], 255);
      chk("dur255_done", dn[0], 1);
      // Retrigger on the third ON cycle, with and without retrig
      clr();
      step(4'b0001, 8'd4, 1'b1, 1'b0);
      step(4'b0000, 8'd4, 1'b1, 1'b0);
      step(4'b0001, 8'd4, 1'b1, 1'b0);
      idle(10);
      chk("retrig_hi", hi[0], 6);
      clr();
      step(4'b0001, 8'd4, 1'b0, 1'b0);
      step(4'b0000, 8'd4, 1'b0, 1'b0);
      step(4'b0001, 8'd4, 1'b0, 1'b0);
      idle(10);
      chk("noretrig_hi", hi[0], 4);
      // Cooldown lockout with b held high
      clr();
      for (int k = 0; k < 15; k++) step(4'b0010, 8'd2, 1'b0, 1'b0);
      chk("lockout_hi", hi[1], 6);
      chk("lockout_done", dn[1], 3);
      idle(6);
      // Kill with three channels active
      step(4'b0111, 8'd5, 1'b0, 1'b0);
      idle(2);
      clr();
      step(4'b0111, 8'd5, 1'b0, 1'b1);
      chk("kill_x", x, 0);
      chk("kill_busy", busy, 0);
      idle(8);
      chk("kill_done", dn[0] + dn[1] + dn[2], 0);
      // Async reset mid-pulse
      step(4'b0100, 8'd10, 1'b0, 1'b0);
      idle(2);
      chk("pre_reset_x2", x[2], 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_x2", x[2], 0);
      chk("async_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clr();
      step(4'b0001, 8'd3, 1'b0, 1'b0);
      idle(7);
      chk("post_reset_hi", hi[0], 3);
      chk("post_reset_busy", bc, 5);
      // Random stimulus
      for (int k = 0; k < 3000; k++) begin
         logic [CH-1:0] rb;
         for (int i = 0; i < CH; i++) rb[i] = $urandom_range(0, 3) == 0;
         step(rb, ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8)),
              1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
